// File: rtl/lpi_ctrl_pkg.sv
// lpi_ctrl_pkg: state encoding, default sizes and saturating increment for the Q-channel controller
package lpi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_REQ     = 3'd1,
        ST_STOPPED = 3'd2,
        ST_EXIT    = 3'd3,
        ST_DENIED  = 3'd4,
        ST_BACKOFF = 3'd5
    } lpi_state_e;

    localparam int IDLE_W_DEF      = 16;
    localparam int CNT_W_DEF       = 8;
    localparam int BACKOFF_CYC_DEF = 16;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/lpi_idle_timer.sv
// lpi_idle_timer: counts qualifying idle cycles in RUN and flags when the live threshold is reached
module lpi_idle_timer
    import lpi_ctrl_pkg::*;
#(
    parameter int IDLE_W = IDLE_W_DEF
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    input  logic              i_run,
    input  logic              i_en,
    input  logic              i_qactive,
    input  logic              i_wake,
    input  logic [IDLE_W-1:0] i_thresh,
    output logic              o_match
);

    logic [IDLE_W-1:0] r_cnt;
    logic [IDLE_W-1:0] w_nxt;
    logic              w_inc;

    // wake or activity clears the count, so a coincident wake always beats the threshold
    assign w_inc   = i_run & i_en & ~i_qactive & ~i_wake & (i_thresh != '0);
    assign w_nxt   = IDLE_W'(sat_inc(32'(r_cnt), 32'({IDLE_W{1'b1}})));
    assign o_match = w_inc & (w_nxt == i_thresh);

    // idle counter: saturating count while idle in RUN, cleared otherwise
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) r_cnt <= '0;
        else          r_cnt <= w_inc ? w_nxt : '0;
    end

endmodule

// File: rtl/lpi_qchannel_ctrl.sv
// lpi_qchannel_ctrl: Q-channel power controller sequencing quiescence of the APB isolator
module lpi_qchannel_ctrl
    import lpi_ctrl_pkg::*;
#(
    parameter int IDLE_W      = IDLE_W_DEF,
    parameter int BACKOFF_CYC = BACKOFF_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    input  logic              en_i,
    input  logic [IDLE_W-1:0] idle_thresh_i,
    input  logic              wake_i,
    input  logic              qactive_i,
    input  logic              qacceptn_i,
    input  logic              qdeny_i,
    output logic              qreqn_o,
    output logic              stopped_o,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  deny_cnt_o,
    output logic              deny_pulse_o,
    output logic              proto_err_o
);

    localparam int BO_W = $clog2(BACKOFF_CYC) + 1;

    lpi_state_e       r_state, w_next;
    logic [BO_W-1:0]  r_bo;
    logic [CNT_W-1:0] r_deny_cnt;
    logic             r_qreqn, r_stopped, r_deny_pulse, r_proto_err;
    logic             w_match, w_qreqn, w_stopped, w_deny_evt, w_proto_evt;

    lpi_idle_timer #(.IDLE_W(IDLE_W)) u_idle (
        .pclk_i    (pclk_i),
        .preset_i  (preset_i),
        .i_run     (r_state == ST_RUN),
        .i_en      (en_i),
        .i_qactive (qactive_i),
        .i_wake    (wake_i),
        .i_thresh  (idle_thresh_i),
        .o_match   (w_match)
    );

    // state register plus registered outputs; reset forces STOPPED with qreqn low
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            r_state      <= ST_STOPPED;
            r_qreqn      <= 1'b0;
            r_stopped    <= 1'b1;
            r_deny_pulse <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_qreqn      <= w_qreqn;
            r_stopped    <= w_stopped;
            r_deny_pulse <= w_deny_evt;
            r_proto_err  <= w_proto_evt;
        end
    end

    // next-state: the request is held in REQ until the device accepts or denies
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN:     w_next = w_match ? ST_REQ : ST_RUN;
            ST_REQ:     w_next = ~qacceptn_i ? ST_STOPPED : (qdeny_i ? ST_DENIED : ST_REQ);
            ST_STOPPED: w_next = (wake_i | qactive_i | ~en_i) ? ST_EXIT : ST_STOPPED;
            ST_EXIT:    w_next = (qacceptn_i & ~qdeny_i) ? ST_RUN : ST_EXIT;
            ST_DENIED:  w_next = qdeny_i ? ST_DENIED : ST_BACKOFF;
            ST_BACKOFF: w_next = (r_bo == '0) ? ST_RUN : ST_BACKOFF;
            default:    w_next = ST_STOPPED;
        endcase
    end

    // output decode: qreqn/stopped follow the next state, events flag denials and protocol violations
    always_comb begin
        w_qreqn     = ~((w_next == ST_REQ) || (w_next == ST_STOPPED));
        w_stopped   = (w_next == ST_STOPPED);
        w_deny_evt  = (r_state == ST_REQ) & qacceptn_i & qdeny_i;
        w_proto_evt = ((r_state == ST_REQ) & ~qacceptn_i & qdeny_i)
                    | ((r_state == ST_EXIT) & qdeny_i)
                    | ((r_state == ST_RUN) & (~qacceptn_i | qdeny_i));
    end

    // backoff timer: loaded when the denial is withdrawn, counts down to the RUN return
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i)                                    r_bo <= '0;
        else if ((r_state == ST_DENIED) && !qdeny_i)     r_bo <= BO_W'(BACKOFF_CYC - 1);
        else if ((r_state == ST_BACKOFF) && (r_bo != '0)) r_bo <= r_bo - BO_W'(1);
    end

    // saturating denial counter
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i)        r_deny_cnt <= '0;
        else if (w_deny_evt) r_deny_cnt <= CNT_W'(sat_inc(32'(r_deny_cnt), 32'({CNT_W{1'b1}})));
    end

    assign qreqn_o      = r_qreqn;
    assign stopped_o    = r_stopped;
    assign state_o      = r_state;
    assign deny_cnt_o   = r_deny_cnt;
    assign deny_pulse_o = r_deny_pulse;
    assign proto_err_o  = r_proto_err;

endmodule

// File: tb/tb_lpi_qchannel_ctrl.sv
// tb_lpi_qchannel_ctrl: directed and randomized checks of the Q-channel controller against a behavioural model
module tb_lpi_qchannel_ctrl;

    localparam int BACKOFF_CYC = 16;
    localparam logic [2:0] M_RUN = 3'd0, M_REQ = 3'd1, M_STOP = 3'd2,
                           M_EXIT = 3'd3, M_DEN = 3'd4, M_BO = 3'd5;

    logic        pclk_i = 1'b0;
    logic        preset_i = 1'b0;
    logic        en_i = 1'b1;
    logic [15:0] idle_thresh_i = 16'd4;
    logic        wake_i = 1'b0;
    logic        qactive_i = 1'b0;
    logic        qacceptn_i = 1'b0;
    logic        qdeny_i = 1'b0;
    logic        qreqn_o, stopped_o, deny_pulse_o, proto_err_o;
    logic [2:0]  state_o;
    logic [7:0]  deny_cnt_o;

    int  total = 0;
    int  bad_cnt = 0;
    bit  chk_en = 0;
    bit  rand_mode = 0;
    bit  force_deny = 0;
    bit  bad_dev = 0;

    lpi_qchannel_ctrl #(.IDLE_W(16), .BACKOFF_CYC(BACKOFF_CYC), .CNT_W(8)) dut (
        .pclk_i        (pclk_i),
        .preset_i      (preset_i),
        .en_i          (en_i),
        .idle_thresh_i (idle_thresh_i),
        .wake_i        (wake_i),
        .qactive_i     (qactive_i),
        .qacceptn_i    (qacceptn_i),
        .qdeny_i       (qdeny_i),
        .qreqn_o       (qreqn_o),
        .stopped_o     (stopped_o),
        .state_o       (state_o),
        .deny_cnt_o    (deny_cnt_o),
        .deny_pulse_o  (deny_pulse_o),
        .proto_err_o   (proto_err_o)
    );

    always #5 pclk_i = ~pclk_i;

    typedef struct packed {
        logic [2:0] m;
        int         idle;
        int         left;
        int         dcnt;
        logic       perr;
        logic       dpulse;
    } ms_t;

    ms_t ms;

    function automatic ms_t mstep(ms_t s, logic en, int thr, logic wk, logic qa, logic ac, logic dn);
        ms_t n = s;
        n.perr = 1'b0;
        n.dpulse = 1'b0;
        case (s.m)
            M_RUN: begin
                if (!ac || dn) n.perr = 1'b1;
                if (en && !qa && !wk && thr != 0) begin
                    n.idle = (s.idle < 65535) ? s.idle + 1 : s.idle;
                    if (n.idle == thr) n.m = M_REQ;
                end else n.idle = 0;
            end
            M_REQ: begin
                if (!ac) begin
                    n.m = M_STOP;
                    n.perr = dn;
                end else if (dn) begin
                    n.m = M_DEN;
                    n.dcnt = (s.dcnt < 255) ? s.dcnt + 1 : 255;
                    n.dpulse = 1'b1;
                end
            end
            M_STOP: if (wk || qa || !en) n.m = M_EXIT;
            M_EXIT: begin
                if (dn) n.perr = 1'b1;
                else if (ac) begin
                    n.m = M_RUN;
                    n.idle = 0;
                end
            end
            M_DEN: if (!dn) begin
                n.m = M_BO;
                n.left = BACKOFF_CYC;
            end
            default: begin
                n.left = s.left - 1;
                if (n.left == 0) begin
                    n.m = M_RUN;
                    n.idle = 0;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) ms <= '{m: M_STOP, idle: 0, left: 0, dcnt: 0, perr: 1'b0, dpulse: 1'b0};
        else ms <= mstep(ms, en_i, int'(idle_thresh_i), wake_i, qactive_i, qacceptn_i, qdeny_i);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge pclk_i) begin
        if (chk_en) begin
            chk("m_state", int'(state_o), int'(ms.m));
            chk("m_qreqn", int'(qreqn_o), int'(!(ms.m == M_REQ || ms.m == M_STOP)));
            chk("m_stopped", int'(stopped_o), int'(ms.m == M_STOP));
            chk("m_deny_cnt", int'(deny_cnt_o), ms.dcnt);
            chk("m_deny_pulse", int'(deny_pulse_o), int'(ms.dpulse));
            chk("m_proto_err", int'(proto_err_o), int'(ms.perr));
        end
    end

    task automatic dev_step();
        if (!qreqn_o && qacceptn_i && !qdeny_i) begin
            if (bad_dev) begin
                qacceptn_i = 1'b0;
                qdeny_i = 1'b1;
            end else if (force_deny) qdeny_i = 1'b1;
            else if (!rand_mode || $urandom_range(0, 1) == 1) begin
                if (rand_mode && $urandom_range(0, 3) == 0) qdeny_i = 1'b1;
                else qacceptn_i = 1'b0;
            end
        end else if (qreqn_o && qdeny_i) begin
            if (!rand_mode || $urandom_range(0, 1) == 1) qdeny_i = 1'b0;
        end else if (qreqn_o && !qacceptn_i) begin
            if (!rand_mode || $urandom_range(0, 1) == 1) qacceptn_i = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge pclk_i);
        #1;
        dev_step();
        if (rand_mode) begin
            en_i = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 49) == 0) idle_thresh_i = 16'($urandom_range(0, 6));
            wake_i = ($urandom_range(0, 19) == 0);
            qactive_i = ($urandom_range(0, 14) == 0);
        end
    endtask

    task automatic cnt_in(input logic [2:0] s, output int n);
        n = 0;
        while (state_o == s && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_st(input logic [2:0] s, input int budget, input string nm);
        int n = 0;
        while (state_o != s && n < budget) begin
            tick();
            n++;
        end
        chk(nm, int'(state_o), int'(s));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int np;
        int cyc;
        #2;
        preset_i = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge pclk_i);
        #1;
        chk("rst_state", int'(state_o), 2);
        chk("rst_qreqn", int'(qreqn_o), 0);
        chk("rst_stopped", int'(stopped_o), 1);
        chk("rst_deny_cnt", int'(deny_cnt_o), 0);
        chk("rst_pulses", int'({deny_pulse_o, proto_err_o}), 0);
        preset_i = 1'b0;

        wake_i = 1'b1;
        tick();
        wake_i = 1'b0;
        chk("exit_state", int'(state_o), 3);
        chk("exit_qreqn", int'(qreqn_o), 1);
        tick();
        chk("run_state", int'(state_o), 0);
        cnt_in(M_RUN, n);
        chk("idle_to_req", n, 4);
        chk("req_qreqn", int'(qreqn_o), 0);
        tick();
        chk("stopped_after_accept", int'(stopped_o), 1);

        qactive_i = 1'b1;
        tick();
        qactive_i = 1'b0;
        chk("qactive_exit", int'(state_o), 3);
        chk("qactive_qreqn", int'(qreqn_o), 1);
        tick();
        chk("qactive_run", int'(state_o), 0);
        force_deny = 1'b1;
        cnt_in(M_RUN, n);
        chk("idle_restart", n, 4);
        tick();
        chk("denied_state", int'(state_o), 4);
        chk("denied_qreqn", int'(qreqn_o), 1);
        chk("denied_cnt", int'(deny_cnt_o), 1);
        chk("denied_pulse", int'(deny_pulse_o), 1);
        tick();
        chk("backoff_state", int'(state_o), 5);
        chk("pulse_one_cycle", int'(deny_pulse_o), 0);
        cnt_in(M_BO, n);
        chk("backoff_len", n, 16);
        force_deny = 1'b0;
        cnt_in(M_RUN, n);
        chk("post_backoff_idle", n, 4);
        tick();
        chk("stop_again", int'(state_o), 2);

        bad_dev = 1'b1;
        wake_i = 1'b1;
        tick();
        wake_i = 1'b0;
        wait_st(M_RUN, 10, "to_run_d");
        cnt_in(M_RUN, n);
        tick();
        chk("illegal_err", int'(proto_err_o), 1);
        chk("illegal_state", int'(state_o), 2);
        bad_dev = 1'b0;
        tick();
        chk("illegal_err_once", int'(proto_err_o), 0);
        chk("illegal_no_deny", int'(deny_cnt_o), 1);
        wake_i = 1'b1;
        tick();
        wake_i = 1'b0;
        wait_st(M_RUN, 10, "to_run_e");

        idle_thresh_i = 16'd0;
        n = 0;
        repeat (1000) begin
            tick();
            if (!qreqn_o || state_o == M_REQ) n++;
        end
        chk("thresh0_no_req", n, 0);
        qdeny_i = 1'b1;
        tick();
        chk("run_err", int'(proto_err_o), 1);
        chk("run_err_state", int'(state_o), 0);
        tick();
        chk("run_err_once", int'(proto_err_o), 0);
        idle_thresh_i = 16'd4;
        wake_i = 1'b1;
        n = 0;
        repeat (1000) begin
            tick();
            if (!qreqn_o || state_o == M_REQ) n++;
        end
        chk("wake_no_req", n, 0);
        wake_i = 1'b0;

        wait_st(M_REQ, 20, "req_before_reset");
        preset_i = 1'b1;
        #1;
        chk("async_state", int'(state_o), 2);
        chk("async_qreqn", int'(qreqn_o), 0);
        #2;
        preset_i = 1'b0;

        idle_thresh_i = 16'd1;
        force_deny = 1'b1;
        wake_i = 1'b1;
        tick();
        wake_i = 1'b0;
        np = 0;
        cyc = 0;
        while (np < 300 && cyc < 20000) begin
            tick();
            cyc++;
            if (deny_pulse_o) np++;
        end
        chk("denials_seen", np, 300);
        chk("deny_saturate", int'(deny_cnt_o), 255);
        force_deny = 1'b0;

        rand_mode = 1'b1;
        repeat (5000) tick();
        rand_mode = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

endmodule
